// File: rtl/knn_topk_pkg.sv
// knn_topk_pkg -- definitions shared by the top-K merge block and its bench.
//   state_t        : COLLECT (accept inputs), EMIT (stream table), STATUS (frame trailer)
//   WORD_W         : width of every data word on the ports
//   DIST_W/LABEL_W : default distance / label field widths, word = {distance, label}
//   DIST_EMPTY     : distance value marking an unfilled table entry
//   STATUS_MARKER  : top byte of the optional status trailer word
package knn_topk_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_EMIT    = 2'd1,
    ST_STATUS  = 2'd2
  } state_t;

  localparam int WORD_W      = 32;
  localparam int DIST_W      = 24;
  localparam int LABEL_W     = 8;
  localparam int CNT_W       = 8;
  localparam int FRAME_IDX_W = 16;

  localparam logic [DIST_W-1:0] DIST_EMPTY    = '1;
  localparam logic [7:0]        STATUS_MARKER = 8'hA5;

endpackage

// File: rtl/knn_topk_merge_if.sv
// knn_topk_merge_if -- bundle of the two candidate input streams and the merged
// result stream (ap_vld/ap_ack handshake, a word moves when both are high).
//   master : environment side (drives inputs and the result ack)
//   slave  : merge block side
interface knn_topk_merge_if;
  import knn_topk_pkg::*;

  logic [WORD_W-1:0] Input_1_V_V;
  logic              Input_1_V_V_ap_vld;
  logic              Input_1_V_V_ap_ack;
  logic [WORD_W-1:0] Input_2_V_V;
  logic              Input_2_V_V_ap_vld;
  logic              Input_2_V_V_ap_ack;
  logic [WORD_W-1:0] Output_1_V_V;
  logic              Output_1_V_V_ap_vld;
  logic              Output_1_V_V_ap_ack;

  modport master (
    output Input_1_V_V, Input_1_V_V_ap_vld, input Input_1_V_V_ap_ack,
    output Input_2_V_V, Input_2_V_V_ap_vld, input Input_2_V_V_ap_ack,
    input  Output_1_V_V, Output_1_V_V_ap_vld, output Output_1_V_V_ap_ack
  );

  modport slave (
    input  Input_1_V_V, Input_1_V_V_ap_vld, output Input_1_V_V_ap_ack,
    input  Input_2_V_V, Input_2_V_V_ap_vld, output Input_2_V_V_ap_ack,
    output Output_1_V_V, Output_1_V_V_ap_vld, input Output_1_V_V_ap_ack
  );

endinterface

// File: rtl/knn_topk_table.sv
// knn_topk_table -- K-entry table kept sorted ascending by distance.
//   clk, rst_n          : clock, synchronous active-low reset (table emptied)
//   clr                 : empty the table (takes priority over insert)
//   ins_en/ins_dist/ins_label : candidate to insert; visible next cycle
//   rd_idx -> rd_dist/rd_label : combinational indexed read
// Insert uses strict less-than, so an equal distance lands behind the entries
// already present and a candidate not below the last entry is dropped.
module knn_topk_table
  import knn_topk_pkg::*;
#(
  parameter int K          = 3,
  parameter int DIST_BITS  = DIST_W,
  parameter int LABEL_BITS = LABEL_W,
  parameter int IDX_W      = (K > 1) ? $clog2(K) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  ins_en,
  input  logic [DIST_BITS-1:0]  ins_dist,
  input  logic [LABEL_BITS-1:0] ins_label,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DIST_BITS-1:0]  rd_dist,
  output logic [LABEL_BITS-1:0] rd_label
);

  localparam logic [DIST_BITS-1:0] EMPTY_D = '1;

  logic [DIST_BITS-1:0]  dist_q  [K];
  logic [DIST_BITS-1:0]  dist_d  [K];
  logic [LABEL_BITS-1:0] label_q [K];
  logic [LABEL_BITS-1:0] label_d [K];
  logic [K-1:0]          lt;

  always_comb begin
    for (int i = 0; i < K; i++) begin
      lt[i]      = ins_dist < dist_q[i];
      dist_d[i]  = dist_q[i];
      label_d[i] = label_q[i];
    end
    if (clr) begin
      for (int i = 0; i < K; i++) begin
        dist_d[i]  = EMPTY_D;
        label_d[i] = '0;
      end
    end else if (ins_en) begin
      // lt is monotonic over a sorted table: the first set bit is the insert
      // slot, every later set bit takes its upper neighbour's old entry.
      if (lt[0]) begin
        dist_d[0]  = ins_dist;
        label_d[0] = ins_label;
      end
      for (int i = 1; i < K; i++) begin
        if (lt[i]) begin
          if (lt[i-1]) begin
            dist_d[i]  = dist_q[i-1];
            label_d[i] = label_q[i-1];
          end else begin
            dist_d[i]  = ins_dist;
            label_d[i] = ins_label;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) begin
        dist_q[i]  <= EMPTY_D;
        label_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < K; i++) begin
        dist_q[i]  <= dist_d[i];
        label_q[i] <= label_d[i];
      end
    end
  end

  always_comb begin
    rd_dist  = EMPTY_D;
    rd_label = '0;
    if (32'(rd_idx) < K) begin
      rd_dist  = dist_q[rd_idx];
      rd_label = label_q[rd_idx];
    end
  end

endmodule

// File: rtl/knn_topk_merge.sv
// knn_topk_merge -- merges two candidate streams into the K nearest per frame.
//   ap_clk   : clock
//   ap_rst_n : synchronous active-low reset
//   bus      : knn_topk_merge_if.slave -- Input_1/Input_2 candidate streams
//              {distance, label}, Output_1 merged result stream
// Each frame takes FRAME_LEN words from each input (one word per cycle overall,
// round-robin when both are offered), then streams table entries 0..K-1.
// Optional feature, macro KNN_TOPK_STATUS_EN: a trailer word
// {8'hA5, 16-bit frame index, 8-bit K} follows each frame's results.
module knn_topk_merge
  import knn_topk_pkg::*;
#(
  parameter int K          = 3,
  parameter int FRAME_LEN  = 64,
  parameter int DIST_BITS  = DIST_W,
  parameter int LABEL_BITS = LABEL_W
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  knn_topk_merge_if.slave bus
);

  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam int W     = DIST_BITS + LABEL_BITS;
  localparam logic [CNT_W-1:0] FL_C     = CNT_W'(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic             grant2_q, grant2_d;  // 1: Input_2 wins a tie next
  logic [IDX_W-1:0] idx_q, idx_d;
`ifdef KNN_TOPK_STATUS_EN
  logic [FRAME_IDX_W-1:0] frame_idx_q, frame_idx_d;
`endif

  logic                  elig1, elig2, take1, take2;
  logic                  tbl_clr, ins_en;
  logic [DIST_BITS-1:0]  ins_dist, rd_dist;
  logic [LABEL_BITS-1:0] ins_label, rd_label;
  logic [WORD_W-1:0]     out_data;
  logic                  out_vld;

  knn_topk_table #(
    .K(K), .DIST_BITS(DIST_BITS), .LABEL_BITS(LABEL_BITS), .IDX_W(IDX_W)
  ) u_table (
    .clk(ap_clk), .rst_n(ap_rst_n), .clr(tbl_clr),
    .ins_en(ins_en), .ins_dist(ins_dist), .ins_label(ins_label),
    .rd_idx(idx_q), .rd_dist(rd_dist), .rd_label(rd_label)
  );

  always_comb begin
    state_d   = state_q;
    cnt1_d    = cnt1_q;
    cnt2_d    = cnt2_q;
    grant2_d  = grant2_q;
    idx_d     = idx_q;
`ifdef KNN_TOPK_STATUS_EN
    frame_idx_d = frame_idx_q;
`endif
    take1     = 1'b0;
    take2     = 1'b0;
    tbl_clr   = 1'b0;
    ins_en    = 1'b0;
    ins_dist  = bus.Input_1_V_V[W-1:LABEL_BITS];
    ins_label = bus.Input_1_V_V[LABEL_BITS-1:0];
    out_data  = '0;
    out_vld   = 1'b0;

    elig1 = bus.Input_1_V_V_ap_vld && (cnt1_q != FL_C);
    elig2 = bus.Input_2_V_V_ap_vld && (cnt2_q != FL_C);

    case (state_q)
      ST_COLLECT: begin
        if (elig1 && (!elig2 || !grant2_q)) begin
          take1 = 1'b1;
        end else if (elig2) begin
          take2 = 1'b1;
        end
        // Priority passes to the other port after every accepted word.
        if (take1) begin
          cnt1_d   = cnt1_q + 1'b1;
          grant2_d = 1'b1;
          ins_en   = 1'b1;
        end
        if (take2) begin
          cnt2_d    = cnt2_q + 1'b1;
          grant2_d  = 1'b0;
          ins_en    = 1'b1;
          ins_dist  = bus.Input_2_V_V[W-1:LABEL_BITS];
          ins_label = bus.Input_2_V_V[LABEL_BITS-1:0];
        end
        if ((cnt1_q == FL_C) && (cnt2_q == FL_C)) begin
          state_d = ST_EMIT;
          idx_d   = '0;
        end
      end

      ST_EMIT: begin
        out_vld  = 1'b1;
        out_data = WORD_W'({rd_dist, rd_label});
        if (bus.Output_1_V_V_ap_ack) begin
          if (idx_q == LAST_IDX) begin
`ifdef KNN_TOPK_STATUS_EN
            state_d = ST_STATUS;
`else
            state_d  = ST_COLLECT;
            tbl_clr  = 1'b1;
            cnt1_d   = '0;
            cnt2_d   = '0;
            grant2_d = 1'b0;
            idx_d    = '0;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_STATUS: begin
`ifdef KNN_TOPK_STATUS_EN
        out_vld  = 1'b1;
        out_data = {STATUS_MARKER, frame_idx_q, 8'(K)};
        if (bus.Output_1_V_V_ap_ack) begin
          frame_idx_d = frame_idx_q + 1'b1;
          state_d     = ST_COLLECT;
          tbl_clr     = 1'b1;
          cnt1_d      = '0;
          cnt2_d      = '0;
          grant2_d    = 1'b0;
          idx_d       = '0;
        end
`else
        state_d = ST_COLLECT;
`endif
      end

      default: state_d = ST_COLLECT;
    endcase
  end

  // Acks are gated by reset so no word is consumed while reset is held.
  assign bus.Input_1_V_V_ap_ack  = take1 && ap_rst_n;
  assign bus.Input_2_V_V_ap_ack  = take2 && ap_rst_n;
  assign bus.Output_1_V_V        = out_data;
  assign bus.Output_1_V_V_ap_vld = out_vld;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q  <= ST_COLLECT;
      cnt1_q   <= '0;
      cnt2_q   <= '0;
      grant2_q <= 1'b0;
      idx_q    <= '0;
`ifdef KNN_TOPK_STATUS_EN
      frame_idx_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt1_q   <= cnt1_d;
      cnt2_q   <= cnt2_d;
      grant2_q <= grant2_d;
      idx_q    <= idx_d;
`ifdef KNN_TOPK_STATUS_EN
      frame_idx_q <= frame_idx_d;
`endif
    end
  end

endmodule
